// File: rtl/mips86_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips86_mem_pkg
// Shared definitions for the memory-side blocks (opcode fetch buffer, store
// buffer, MMU): default bus/address widths, the store-buffer FSM encoding and
// the byte-offset width of a bus word.
// ---------------------------------------------------------------------------
package mips86_mem_pkg;

  localparam int DEFAULT_BUS_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } sb_state_e;

  // Number of low address bits that select a byte inside one bus word.
  function automatic int word_offset_bits(input int bus_width);
    return $clog2(bus_width / 8);
  endfunction

endpackage

// File: rtl/word_store_buffer_fifo.sv
// ---------------------------------------------------------------------------
// store_fifo
// In-order FIFO of pending word stores with a parallel forwarding lookup.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_addr,  offer an entry; taken only when ready is high
//   push_data
//   pop               retire the head entry
//   ready             registered "not full"
//   count             number of valid entries (0..DEPTH)
//   head_addr/data    oldest entry
//   lookup_addr       word-aligned query address
//   lookup_hit/data   youngest matching entry, data is 0 on a miss
// ---------------------------------------------------------------------------
module store_fifo #(
  parameter  int DEPTH      = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int BUS_WIDTH  = 32,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [BUS_WIDTH-1:0]  push_data,
  input  logic                  pop,
  output logic                  ready,
  output logic [CNT_W-1:0]      count,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [BUS_WIDTH-1:0]  head_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [BUS_WIDTH-1:0]  lookup_data
);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [BUS_WIDTH-1:0]  data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [CNT_W-1:0]      count_next;

  // A push while full is dropped even if the head retires on the same edge.
  assign push_ok    = push && ready;
  assign pop_ok     = pop && (count != '0);
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      ready <= (count_next != CNT_W'(DEPTH));
    end
  end

  // NOTE: the storage array has no reset; every read is qualified by count,
  // so stale contents are never observable and the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Walk from oldest to youngest so a later match overrides an earlier one.
  // NOTE: every output of this block is given a default first, otherwise the
  // paths that skip an assignment would infer latches.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int age = 0; age < DEPTH; age++) begin
      idx = rd_ptr + PTR_W'(age);
      if ((CNT_W'(age) < count) && (addr_mem[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/word_store_buffer.sv
// ---------------------------------------------------------------------------
// word_store_buffer
// Buffers word stores from the core and drains them, oldest first, to an MMU
// write port using the request/busy handshake. Pending stores are visible to
// fetches and loads through the forwarding lookup until they complete.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   storeAddr/Data/Valid       store from the core; storeReady = not full
//   memAddr/memData            word-aligned write address and data to MMU
//   memWriteEnable, memRequest write transaction controls
//   memBusy                    MMU busy: rise = acknowledge, fall = done
//   lookupAddr                 forwarding query
//   lookupHit/lookupData       youngest pending store to the same word
//   empty                      nothing pending and FSM idle
// ---------------------------------------------------------------------------
module word_store_buffer
  import mips86_mem_pkg::*;
#(
  parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] storeAddr,
  input  logic [BUS_WIDTH-1:0]  storeData,
  input  logic                  storeValid,
  output logic                  storeReady,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [BUS_WIDTH-1:0]  memData,
  output logic                  memWriteEnable,
  output logic                  memRequest,
  input  logic                  memBusy,
  input  logic [ADDR_WIDTH-1:0] lookupAddr,
  output logic                  lookupHit,
  output logic [BUS_WIDTH-1:0]  lookupData,
  output logic                  empty
);

  localparam int                  OFF        = word_offset_bits(BUS_WIDTH);
  localparam int                  CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF;

  sb_state_e             state, state_next;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [BUS_WIDTH-1:0]  head_data;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [BUS_WIDTH-1:0]  data_next;
  logic                  req_next;
  logic                  we_next;
  logic                  pop;

  store_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (storeValid),
    .push_addr  (storeAddr & ALIGN_MASK),
    .push_data  (storeData),
    .pop        (pop),
    .ready      (storeReady),
    .count      (count),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .lookup_addr(lookupAddr & ALIGN_MASK),
    .lookup_hit (lookupHit),
    .lookup_data(lookupData)
  );

  // The head is only popped on the completion edge, so it keeps forwarding
  // while its write is in flight.
  always_comb begin
    state_next = state;
    addr_next  = memAddr;
    data_next  = memData;
    req_next   = memRequest;
    we_next    = memWriteEnable;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          addr_next  = head_addr;
          data_next  = head_data;
          req_next   = 1'b1;
          we_next    = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Busy already high on entry counts as the acknowledge.
        if (memBusy) begin
          req_next   = 1'b0;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!memBusy) begin
          pop        = 1'b1;
          we_next    = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      memAddr        <= '0;
      memData        <= '0;
      memRequest     <= 1'b0;
      memWriteEnable <= 1'b0;
    end else begin
      state          <= state_next;
      memAddr        <= addr_next;
      memData        <= data_next;
      memRequest     <= req_next;
      memWriteEnable <= we_next;
    end
  end

  assign empty = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_word_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_word_store_buffer
// Directed bench for word_store_buffer. A small MMU model answers write
// transactions and stores completed words in its own memory; every accepted
// store is queued as an expected write and matched when the MMU completes it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_word_store_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  localparam int ACK_DELAY = 1;
  localparam int HOLD      = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] storeAddr;
  logic [31:0] storeData;
  logic        storeValid;
  logic        storeReady;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memWriteEnable;
  logic        memRequest;
  logic        memBusy;
  logic [31:0] lookupAddr;
  logic        lookupHit;
  logic [31:0] lookupData;
  logic        empty;

  int          checks;
  int          errors;
  wr_t         exp_q[$];
  logic [31:0] mmu_mem [0:63];
  int          mmu_phase;
  int          mmu_cnt;
  bit          mmu_stall;
  bit          gap_check;
  bit          gap_pending;
  int          cyc;
  int          last_commit;
  int          wr_count;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic        req_prev;

  word_store_buffer #(.BUS_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .storeAddr     (storeAddr),
    .storeData     (storeData),
    .storeValid    (storeValid),
    .storeReady    (storeReady),
    .memAddr       (memAddr),
    .memData       (memData),
    .memWriteEnable(memWriteEnable),
    .memRequest    (memRequest),
    .memBusy       (memBusy),
    .lookupAddr    (lookupAddr),
    .lookupHit     (lookupHit),
    .lookupData    (lookupData),
    .empty         (empty)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    storeAddr  = a;
    storeData  = d;
    storeValid = 1'b1;
    if (storeReady) exp_q.push_back('{a & 32'hFFFF_FFFC, d});
    tick();
    storeValid = 1'b0;
  endtask

  task automatic lookup_check(input string tag, input logic [31:0] a,
                              input logic hit, input logic [31:0] d);
    lookupAddr = a;
    #1;
    check({tag, "_hit"}, lookupHit, hit);
    check({tag, "_data"}, lookupData, d);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int i = 0; i < budget && !empty; i++) tick();
    check(tag, empty, 1'b1);
  endtask

  // MMU model: acknowledges a request after ACK_DELAY, holds busy for HOLD
  // cycles (longer while stalled) and commits the word on the falling edge.
  task automatic mmu_loop();
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        memBusy     = 1'b0;
        mmu_phase   = 0;
        mmu_cnt     = 0;
        gap_pending = 1'b0;
      end else begin
        if (memRequest && !req_prev && gap_pending) begin
          check("idle_gap", cyc - last_commit, 2);
          gap_pending = 1'b0;
        end
        case (mmu_phase)
          0: if (memRequest) begin
            mmu_cnt++;
            if (mmu_cnt >= ACK_DELAY) begin
              memBusy   = 1'b1;
              cap_addr  = memAddr;
              cap_data  = memData;
              mmu_phase = 1;
              mmu_cnt   = 0;
            end
          end
          default: begin
            mmu_cnt++;
            if (mmu_cnt >= HOLD && !mmu_stall) begin
              check("wr_enable", memWriteEnable, 1'b1);
              check("wr_addr_stable", memAddr, cap_addr);
              check("wr_data_stable", memData, cap_data);
              check("wr_expected", exp_q.size() != 0, 1'b1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", memAddr, e.addr);
                check("wr_data", memData, e.data);
              end
              mmu_mem[memAddr[7:2]] = memData;
              wr_count++;
              memBusy     = 1'b0;
              mmu_phase   = 0;
              mmu_cnt     = 0;
              last_commit = cyc;
              if (gap_check) gap_pending = 1'b1;
            end
          end
        endcase
      end
      req_prev = memRequest;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wr_before;
    bit          saw_req;
    logic [31:0] opcode;

    checks = 0; errors = 0; cyc = 0; last_commit = 0; wr_count = 0;
    mmu_phase = 0; mmu_cnt = 0; mmu_stall = 0; gap_check = 0; gap_pending = 0;
    req_prev = 1'b0; memBusy = 1'b0;
    storeAddr = '0; storeData = '0; storeValid = 1'b0; lookupAddr = '0;
    for (int i = 0; i < 64; i++) mmu_mem[i] = '0;

    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_req", memRequest, 1'b0);
    check("rst_we", memWriteEnable, 1'b0);
    check("rst_addr", memAddr, 32'h0);
    check("rst_data", memData, 32'h0);
    check("rst_ready", storeReady, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_hit", lookupHit, 1'b0);

    fork
      mmu_loop();
    join_none

    tick();
    reset = 1'b1;
    tick();
    tick();

    // Single store: misaligned address is aligned, request one edge later.
    push(32'h0000_0006, 32'hDEAD_BEEF);
    check("t1_req_not_yet", memRequest, 1'b0);
    check("t1_not_empty", empty, 1'b0);
    lookup_check("t1_fwd", 32'h0000_0004, 1'b1, 32'hDEAD_BEEF);
    tick();
    check("t1_req", memRequest, 1'b1);
    check("t1_we", memWriteEnable, 1'b1);
    check("t1_addr", memAddr, 32'h0000_0004);
    check("t1_data", memData, 32'hDEAD_BEEF);
    for (int i = 0; i < 20 && memRequest; i++) tick();
    check("t1_req_dropped", memRequest, 1'b0);
    check("t1_busy_at_drop", memBusy, 1'b1);
    for (int i = 0; i < 20 && memBusy; i++) begin
      check("t1_busy_not_empty", empty, 1'b0);
      tick();
    end
    check("t1_empty_after_done", empty, 1'b1);
    check("t1_readback", mmu_mem[1], 32'hDEAD_BEEF);

    // Fill with the MMU stalled, 5th store dropped, then ordered drain.
    mmu_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i * 4), 32'h1000_0000 + 32'(i));
    check("t2_full", storeReady, 1'b0);
    push(32'h24, 32'hBAD0_BAD0);
    check("t2_still_full", storeReady, 1'b0);
    lookup_check("t2_dropped", 32'h24, 1'b0, 32'h0);
    gap_check = 1'b1;
    mmu_stall = 1'b0;
    wait_empty("t2_drain", 200);
    gap_check   = 1'b0;
    gap_pending = 1'b0;
    check("t2_sb_drained", exp_q.size(), 0);

    // Two stores to one word: youngest wins.
    mmu_stall = 1'b1;
    push(32'h20, 32'h1111_1111);
    push(32'h20, 32'h2222_2222);
    lookup_check("t3_young", 32'h23, 1'b1, 32'h2222_2222);
    lookup_check("t3_miss", 32'h24, 1'b0, 32'h0);
    mmu_stall = 1'b0;
    wait_empty("t3_drain", 100);
    lookup_check("t3_gone", 32'h20, 1'b0, 32'h0);
    check("t3_mem", mmu_mem[8], 32'h2222_2222);

    // Asynchronous reset during WAIT_DONE with two entries pending.
    mmu_stall = 1'b1;
    push(32'h30, 32'hAAAA_0001);
    push(32'h34, 32'hAAAA_0002);
    for (int i = 0; i < 10 && !(memBusy && !memRequest); i++) tick();
    check("t4_in_wait_done", memBusy && !memRequest && memWriteEnable, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t4_req_async", memRequest, 1'b0);
    check("t4_we_async", memWriteEnable, 1'b0);
    check("t4_empty", empty, 1'b1);
    check("t4_ready", storeReady, 1'b1);
    lookup_check("t4_lookup", 32'h30, 1'b0, 32'h0);
    exp_q.delete();
    mmu_stall = 1'b0;
    tick();
    reset = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw_req = saw_req | memRequest;
    end
    check("t4_no_req_after", saw_req, 1'b0);

    // Full FIFO: completion and a store offered on the same edge.
    wr_before = wr_count;
    mmu_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h40 + 32'(i * 4), 32'hC000_0000 + 32'(i));
    check("t5_full", storeReady, 1'b0);
    repeat (4) tick();
    check("t5_wait_done", memBusy && !memRequest, 1'b1);
    storeAddr  = 32'h50;
    storeData  = 32'h5555_5555;
    storeValid = 1'b1;
    mmu_stall  = 1'b0;
    tick();
    storeValid = 1'b0;
    check("t5_ready_after_pop", storeReady, 1'b1);
    lookup_check("t5_rejected", 32'h50, 1'b0, 32'h0);
    lookup_check("t5_popped", 32'h40, 1'b0, 32'h0);
    lookup_check("t5_tail", 32'h4C, 1'b1, 32'hC000_0003);
    tick();
    wait_empty("t5_drain", 200);
    check("t5_write_count", wr_count - wr_before, 4);

    // Store an opcode, then fetch it back through the same MMU memory.
    push(32'h0, 32'h3C01_0001);
    wait_empty("t6_drain", 100);
    opcode = mmu_mem[0];
    check("t6_fetch_opcode", opcode, 32'h3C01_0001);
    check("sb_final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_store_buffer.md
Name: word_store_buffer

Overview:
- Write-side companion to the word opcode fetch buffer: the fetch buffer reads words from the MMU port, this block writes them.
- Accepts word stores from the core and holds them in a small in-order FIFO. Drains them one at a time to an MMU port using the request/busy handshake, with writeEnable asserted.
- Provides a store-to-load forwarding lookup so fetches and loads see stores that have not yet drained.

Parameters:
- BUS_WIDTH, 32, data word width in bits (multiple of 8).
- ADDR_WIDTH, 32, address width in bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- storeAddr  input  ADDR_WIDTH  store byte address. Low log2(BUS_WIDTH/8) bits are ignored.
- storeData  input  BUS_WIDTH  store word.
- storeValid  input  1  store offered this cycle.
- storeReady  output  1  FIFO can accept a store (not full).
- memAddr  output  ADDR_WIDTH  word-aligned address to MMU.
- memData  output  BUS_WIDTH  write data to MMU.
- memWriteEnable  output  1  high for the whole write transaction.
- memRequest  output  1  transaction request to MMU.
- memBusy  input  1  MMU busy; the rising edge acknowledges, the falling edge completes.
- lookupAddr  input  ADDR_WIDTH  forwarding query address.
- lookupHit  output  1  some pending entry matches the word address.
- lookupData  output  BUS_WIDTH  data of the youngest matching entry.
- empty  output  1  no pending stores and FSM idle.

Behaviour:
- Reset (reset low, asynchronous), all immediately:
  - FIFO cleared and count = 0.
  - FSM forced to IDLE.
  - memRequest, memWriteEnable, memAddr and memData all 0.
  - storeReady = 1, empty = 1, lookupHit = 0.
  - A transaction in flight is abandoned; its entry is lost.
- Accept: a push occurs on a rising edge with storeValid && storeReady.
  - storeReady = (count != DEPTH) and is registered.
  - A push while full is ignored, even if a pop happens in the same cycle.
  - Push and pop in the same cycle: count is unchanged and both take effect.
- Address handling: stored addresses are forced word-aligned (low bits zeroed). memAddr is always aligned.
- FSM states:
  - IDLE:
    - If count != 0, load the head entry into memAddr/memData.
    - Set memRequest = 1 and memWriteEnable = 1, then go to WAIT_ACK.
  - WAIT_ACK:
    - Hold memRequest.
    - When memBusy = 1, clear memRequest and go to WAIT_DONE.
  - WAIT_DONE:
    - When memBusy = 0, pop the head, clear memWriteEnable and go to IDLE.
- Latency: a store pushed at edge N has memRequest high from edge N+1.
- One IDLE cycle separates back-to-back transactions.
- memAddr/memData are stable from memRequest rise until the pop edge.
- Minimum transaction time is 3 cycles plus the MMU busy time.
- Head lifetime: the head stays in the FIFO until its completion edge, so lookup still hits it while in flight.
- Pointers: read and write pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Lookup (combinational):
  - Compares word addresses (low bits masked) against all valid entries.
  - The youngest match wins, i.e. the highest age from the head.
  - lookupData = 0 when there is no hit.
  - An entry pushed this cycle is not visible until after the edge.
  - An entry popped this cycle is visible until the edge.
- empty = (count == 0) && (state == IDLE).
- memBusy high while in IDLE is ignored. In WAIT_ACK, memBusy already high is taken as the acknowledge.

Decomposition:
- Package mips86_mem_pkg holds:
  - the store-buffer state enum (IDLE, WAIT_ACK, WAIT_DONE);
  - the word-offset width function log2(BUS_WIDTH/8);
  - the default BUS_WIDTH/ADDR_WIDTH constants shared with the opcode buffer and MMU.
- One sub-module: store_fifo.
  - Synchronous DEPTH-entry FIFO with count, head outputs and parallel youngest-match lookup.
  - The top level is the FSM plus the output registers.

Test Plan:
- Reset, then push storeAddr 0x0000_0006, data 0xDEADBEEF. MMU model raises busy 1 cycle after request and holds it 3 cycles. Required:
  - memRequest rises 1 edge after the push.
  - memAddr = 0x0000_0004 and memData = 0xDEADBEEF throughout.
  - memRequest drops after busy rises.
  - empty = 1 one edge after busy falls.
  - SimpleMmu readback of addr 4 returns 0xDEADBEEF.
- With busy held high, push 4 stores to addresses 0x10, 0x14, 0x18, 0x1C. Required:
  - storeReady = 0 after the 4th push.
  - A 5th push is ignored.
  - After release, writes occur in order with exactly one IDLE cycle between them.
- Push 0x20 = 0x11111111, then 0x20 = 0x22222222, while the MMU stalls. With lookupAddr 0x23, required: lookupHit = 1 and lookupData = 0x22222222.
- Assert reset low mid-WAIT_DONE with 2 entries pending. Required:
  - memRequest/memWriteEnable go to 0 immediately, without waiting for a clock edge.
  - empty = 1 and lookupHit = 0.
  - No further requests after reset releases.
- Full FIFO and busy falls while storeValid is high in the same cycle. Required:
  - The pop occurs and the push is rejected.
  - storeReady = 1 the next cycle.
  - count = 3.
- Fetch/store interplay: write 0x0 = 0x3C010001 via this block, then the opcode buffer fetches ip 0 through the same SimpleMmu. Required: the fetched opcode is 3C010001.
